// File: rtl/tile_mem_ctrl.sv
// Board tile memory sequencer: bulk-loads a shuffled board image, then shares the
// memory's combinational read port between game-logic lookups and a display scanner.
module tile_mem_ctrl #(
  parameter int N_EDGE   = 24,
  parameter int N_CENTER = 12,
  parameter int AW       = 6,
  parameter int DW       = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [N_EDGE*DW-1:0]     edge_word_in,
  input  logic [N_CENTER*DW-1:0]   center_word_in,
  output logic                     WR,
  output logic [N_EDGE*DW-1:0]     EDGE_DATA_OUT,
  output logic [N_CENTER*DW-1:0]   CENTER_DATA_OUT,
  output logic [AW-1:0]            ADDR,
  input  logic [DW-1:0]            DATA_IN,
  input  logic                     lk_req,
  input  logic [AW-1:0]            lk_addr,
  output logic                     lk_ack,
  output logic [DW-1:0]            lk_data,
  output logic                     lk_err,
  input  logic                     scan_en,
  output logic                     scan_valid,
  output logic [AW-1:0]            scan_addr,
  output logic [DW-1:0]            scan_data,
  output logic                     ready,
  output logic                     busy
);

  localparam int N_TILES = N_EDGE + N_CENTER;

  typedef enum logic [1:0] {IDLE, LOAD, SERVE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic            lk_pending, rr;
  logic [AW-1:0]   scan_ptr;
  logic            vld_p0, is_lk_p0, err_p0;
  logic [AW-1:0]   saddr_p0;
  logic            lk_elig, sc_elig, grant_lk, grant_sc;

  function automatic logic in_range(input logic [AW-1:0] a);
    return a < AW'(N_TILES);
  endfunction

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(N_TILES - 1)) ? '0 : p + 1'b1;
  endfunction

  assign lk_elig = lk_req && !lk_pending;
  assign sc_elig = scan_en;
  assign WR      = (state == LOAD);
  assign ready   = (state == SERVE);
  assign busy    = (state == LOAD) || (state == DRAIN);

  // rr=0 favours the lookup side; it flips only when both sides compete.
  always_comb begin
    state_nxt = state;
    grant_lk  = 1'b0;
    grant_sc  = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = LOAD;
      LOAD:  state_nxt = SERVE;
      SERVE: begin
        if (start) begin
          state_nxt = DRAIN;
        end else if (lk_elig && sc_elig) begin
          grant_sc = rr;
          grant_lk = !rr;
        end else begin
          grant_lk = lk_elig;
          grant_sc = sc_elig;
        end
      end
      DRAIN: if (!vld_p0) state_nxt = LOAD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      EDGE_DATA_OUT   <= '0;
      CENTER_DATA_OUT <= '0;
      ADDR            <= '0;
      lk_pending      <= 1'b0;
      rr              <= 1'b0;
      scan_ptr        <= '0;
      vld_p0          <= 1'b0;
      is_lk_p0        <= 1'b0;
      err_p0          <= 1'b0;
      saddr_p0        <= '0;
      lk_ack          <= 1'b0;
      lk_data         <= '0;
      lk_err          <= 1'b0;
      scan_valid      <= 1'b0;
      scan_addr       <= '0;
      scan_data       <= '0;
    end else begin
      state <= state_nxt;
      if (start && (state == IDLE || state == SERVE)) begin
        EDGE_DATA_OUT   <= edge_word_in;
        CENTER_DATA_OUT <= center_word_in;
      end

      // Stage p0: grant registered, ADDR drives the memory
      vld_p0 <= grant_lk || grant_sc;
      if (grant_lk || grant_sc) begin
        is_lk_p0 <= grant_lk;
        err_p0   <= grant_lk && !in_range(lk_addr);
        saddr_p0 <= scan_ptr;
      end
      if (grant_sc) begin
        ADDR     <= scan_ptr;
        scan_ptr <= next_ptr(scan_ptr);
      end else if (grant_lk && in_range(lk_addr)) begin
        ADDR <= lk_addr;
      end
      if (lk_elig && sc_elig && (grant_lk || grant_sc)) rr <= !rr;
      // Pending stays set through the ack cycle so a still-held request is not regranted.
      if (grant_lk)    lk_pending <= 1'b1;
      else if (lk_ack) lk_pending <= 1'b0;

      // Stage p1: DATA_IN captured, result pulses out
      lk_ack     <= vld_p0 && is_lk_p0;
      scan_valid <= vld_p0 && !is_lk_p0;
      if (vld_p0 && is_lk_p0) begin
        lk_data <= err_p0 ? '0 : DATA_IN;
        lk_err  <= err_p0;
      end
      if (vld_p0 && !is_lk_p0) begin
        scan_addr <= saddr_p0;
        scan_data <= DATA_IN;
      end
    end
  end

endmodule

// File: tb/tb_tile_mem_ctrl.sv
// Self-checking bench for tile_mem_ctrl: behavioural tile memory, board-image
// reference model, table-driven lookups, hand sequences and randomized traffic.
module tb_tile_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, start, WR, lk_req, lk_ack, lk_err, scan_en, scan_valid, ready, busy;
  logic [95:0] edge_word_in, EDGE_DATA_OUT;
  logic [47:0] center_word_in, CENTER_DATA_OUT;
  logic [5:0]  ADDR, lk_addr, scan_addr;
  logic [3:0]  DATA_IN, lk_data, scan_data;

  always #5 clk = ~clk;

  tile_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .edge_word_in(edge_word_in), .center_word_in(center_word_in),
    .WR(WR), .EDGE_DATA_OUT(EDGE_DATA_OUT), .CENTER_DATA_OUT(CENTER_DATA_OUT),
    .ADDR(ADDR), .DATA_IN(DATA_IN),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_ack(lk_ack), .lk_data(lk_data), .lk_err(lk_err),
    .scan_en(scan_en), .scan_valid(scan_valid), .scan_addr(scan_addr), .scan_data(scan_data),
    .ready(ready), .busy(busy)
  );

  // External tile memory: written in bulk on WR, read combinationally.
  logic [3:0] mem [64] = '{default: 4'h0};
  always @(posedge clk) begin
    if (WR) begin
      for (int i = 0; i < 24; i++) mem[i] <= EDGE_DATA_OUT[95-4*i -: 4];
      for (int j = 0; j < 12; j++) mem[24+j] <= CENTER_DATA_OUT[47-4*j -: 4];
    end
  end
  assign DATA_IN = mem[ADDR];

  // Reference model: the board as the game sees it, plus the image waiting to be written.
  logic [3:0] ref_board  [36] = '{default: 4'h0};
  logic [3:0] pend_board [36] = '{default: 4'h0};

  int checks = 0, errors = 0;
  int exp_ptr = 0, scan_cnt = 0, ack_cnt = 0;
  bit lk_outstanding = 0, rst_smp = 1;
  bit track_gap = 0, gap_seen = 0;
  int gap = 0, max_gap = 0;

  typedef struct {
    logic [5:0] addr;
    logic [3:0] data;
    logic       err;
  } lk_vec_t;
  lk_vec_t tbl [10];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_board(input logic [95:0] e, input logic [47:0] c);
    edge_word_in   = e;
    center_word_in = c;
    for (int i = 0; i < 24; i++) pend_board[i] = e[95-4*i -: 4];
    for (int j = 0; j < 12; j++) pend_board[24+j] = c[47-4*j -: 4];
  endtask

  // Observes the cycle just entered: scanner order/data, stray acks, scanner gaps, board commit.
  task automatic monitor();
    if (!rst_smp) exp_ptr = 0;
    if (scan_valid) begin
      chk("scan_addr", scan_addr, exp_ptr);
      chk("scan_data", scan_data, ref_board[exp_ptr]);
      exp_ptr = (exp_ptr + 1) % 36;
      scan_cnt++;
    end
    if (lk_ack) begin
      chk("ack_expected", lk_outstanding, 1);
      ack_cnt++;
    end
    if (track_gap) begin
      if (scan_valid) begin
        if (gap_seen && gap > max_gap) max_gap = gap;
        gap = 0;
        gap_seen = 1;
      end else begin
        gap++;
      end
    end
    if (WR) for (int i = 0; i < 36; i++) ref_board[i] = pend_board[i];
  endtask

  task automatic cyc();
    rst_smp = rst_n;
    @(posedge clk);
    #2;
    monitor();
  endtask

  task automatic do_lookup(input logic [5:0] a, input logic [3:0] ed, input logic ee, input string tag);
    logic [5:0] a0;
    bit got;
    a0 = ADDR;
    lk_addr = a;
    lk_req = 1'b1;
    lk_outstanding = 1;
    got = 0;
    for (int n = 0; n < 30 && !got; n++) begin
      cyc();
      if (lk_ack) got = 1;
    end
    chk({tag, "_ack"}, got, 1);
    if (got) begin
      chk({tag, "_data"}, lk_data, ed);
      chk({tag, "_err"}, lk_err, ee);
      if (!scan_en) chk({tag, "_addr"}, ADDR, ee ? a0 : a);
    end
    lk_req = 1'b0;
    lk_outstanding = 0;
  endtask

  initial begin
    logic [95:0] e3;
    logic [47:0] c3;
    logic [5:0]  ra;
    int c0, a0cnt, v;
    bit found;

    tbl[0] = '{6'd25, 4'hE, 1'b0};
    tbl[1] = '{6'd0,  4'h0, 1'b0};
    tbl[2] = '{6'd7,  4'h7, 1'b0};
    tbl[3] = '{6'd15, 4'hF, 1'b0};
    tbl[4] = '{6'd23, 4'h7, 1'b0};
    tbl[5] = '{6'd24, 4'hF, 1'b0};
    tbl[6] = '{6'd35, 4'h4, 1'b0};
    tbl[7] = '{6'd36, 4'h0, 1'b1};
    tbl[8] = '{6'd40, 4'h0, 1'b1};
    tbl[9] = '{6'd63, 4'h0, 1'b1};

    rst_n = 0; start = 0; lk_req = 0; lk_addr = '0; scan_en = 0;
    edge_word_in = '0; center_word_in = '0;
    repeat (3) cyc();
    chk("rst_ctrl", {WR, ready, busy, lk_ack, scan_valid, lk_err}, 6'b0);
    chk("rst_data", {ADDR, lk_data, scan_addr, scan_data}, 20'h0);
    chk("rst_image", {EDGE_DATA_OUT, CENTER_DATA_OUT}, 144'h0);

    // Initial load
    rst_n = 1;
    cyc();
    set_board(96'h0123456789ABCDEF01234567, 48'hFEDCBA987654);
    start = 1;
    chk("load_wr_pre", WR, 0);
    cyc();
    start = 0;
    chk("load_wr", WR, 1);
    chk("load_busy", {busy, ready}, 2'b10);
    chk("load_edge", EDGE_DATA_OUT, 96'h0123456789ABCDEF01234567);
    chk("load_center", CENTER_DATA_OUT, 48'hFEDCBA987654);
    cyc();
    chk("load_wr_post", WR, 0);
    chk("load_ready", {ready, busy}, 2'b10);

    // Lookup latency with the request held through the ack
    a0cnt = ack_cnt;
    lk_addr = 6'd25; lk_req = 1; lk_outstanding = 1;
    cyc();
    chk("lat_addr", ADDR, 6'd25);
    chk("lat_noack", lk_ack, 0);
    cyc();
    chk("lat_ack", lk_ack, 1);
    chk("lat_data", {lk_err, lk_data}, 5'h0E);
    cyc();
    lk_req = 0; lk_outstanding = 0;
    repeat (4) cyc();
    chk("lat_one_ack", ack_cnt - a0cnt, 1);

    for (int i = 0; i < 10; i++) do_lookup(tbl[i].addr, tbl[i].data, tbl[i].err, "tbl");
    repeat (2) cyc();

    // Scanner alone for 40 cycles
    c0 = scan_cnt; track_gap = 1; gap_seen = 0; gap = 0; max_gap = 0;
    scan_en = 1;
    repeat (40) cyc();
    scan_en = 0;
    repeat (3) cyc();
    track_gap = 0;
    chk("scan40_count", scan_cnt - c0, 40);
    chk("scan40_gap", max_gap, 0);

    // Scanner contending with back-to-back lookups
    scan_en = 1; track_gap = 1; gap_seen = 0; gap = 0; max_gap = 0;
    for (int i = 0; i < 6; i++) do_lookup(6'd7, 4'h7, 1'b0, "cont");
    repeat (3) cyc();
    track_gap = 0;
    chk("cont_gap", max_gap <= 1, 1);
    scan_en = 0;
    repeat (3) cyc();

    // Reload from SERVE with reads in flight
    scan_en = 1;
    repeat (5) cyc();
    set_board(~96'h0123456789ABCDEF01234567, ~48'hFEDCBA987654);
    start = 1;
    chk("drain_valid_at_start", scan_valid, 1);
    cyc();
    start = 0;
    chk("drain_busy", busy, 1);
    found = 0; v = 0;
    for (int k = 0; k < 10; k++) begin
      if (WR) begin
        found = 1;
        break;
      end
      v += int'(scan_valid);
      cyc();
    end
    chk("drain_wr_seen", found, 1);
    chk("drain_inflight_done", v, 1);
    chk("drain_quiet_wr", {scan_valid, lk_ack}, 2'b00);
    c0 = scan_cnt;
    repeat (10) cyc();
    chk("reload_scans", scan_cnt - c0 >= 5, 1);
    scan_en = 0;
    repeat (3) cyc();

    // Randomized lookups against the board model
    for (int i = 0; i < 40; i++) begin
      scan_en = 1'($urandom_range(0, 1));
      ra = 6'($urandom_range(0, 47));
      do_lookup(ra, (ra < 6'd36) ? ref_board[ra] : 4'h0, ra >= 6'd36, "rnd");
      repeat ($urandom_range(0, 2)) cyc();
    end
    scan_en = 0;
    repeat (3) cyc();

    // Reset while scanner reads are in flight
    scan_en = 1;
    repeat (3) cyc();
    rst_n = 0;
    cyc();
    chk("rst_fly_quiet", {scan_valid, lk_ack, ready}, 3'b000);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("rst_fly_idle", {scan_valid, ready}, 2'b00);
    end
    scan_en = 0;

    // Reset during LOAD with a lookup parked outside SERVE
    e3 = {$urandom, $urandom, $urandom};
    c3 = {$urandom, 16'($urandom)};
    lk_addr = 6'd3; lk_req = 1;
    set_board(e3, c3);
    start = 1;
    cyc();
    start = 0;
    chk("rl_wr", WR, 1);
    rst_n = 0;
    cyc();
    chk("rl_after", {WR, ready, busy}, 3'b000);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("rl_idle", {lk_ack, ready}, 2'b00);
    end

    // Parked lookup is served once the board is up again
    start = 1;
    cyc();
    start = 0;
    do_lookup(6'd3, ref_board[3], 1'b0, "park");
    scan_en = 1;
    repeat (8) cyc();
    scan_en = 0;
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_mem_ctrl.md
Name: tile_mem_ctrl

Overview:
- Sequences and shares the 36-entry x 4-bit board tile memory: 24 edge entries at addresses 0-23, 12 center entries at 24-35.
- On `start`, latches a shuffled board image and issues a single bulk write cycle.
- Afterwards, arbitrates the memory's single combinational read port between:
  - game-logic lookups (req/ack handshake);
  - a free-running display scanner.

Parameters:
- N_EDGE, 24, number of edge tiles (memory addresses 0..N_EDGE-1).
- N_CENTER, 12, number of center tiles (addresses N_EDGE..N_EDGE+N_CENTER-1).
- AW, 6, address width.
- DW, 4, tile code width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request to (re)load the board; single-cycle pulse.
- edge_word_in  in  96  shuffled edge tiles; tile 0 in [95:92].
- center_word_in  in  48  shuffled center tiles; tile 24 in [47:44].
- WR  out  1  memory write strobe.
- EDGE_DATA_OUT  out  96  edge image to memory.
- CENTER_DATA_OUT  out  48  center image to memory.
- ADDR  out  6  memory read address, registered.
- DATA_IN  in  4  memory read data; combinational from ADDR.
- lk_req  in  1  lookup request; held with lk_addr stable until lk_ack.
- lk_addr  in  6  lookup address.
- lk_ack  out  1  one-cycle pulse; lk_data and lk_err valid in that cycle.
- lk_data  out  4  lookup result.
- lk_err  out  1  lookup address was >= 36.
- scan_en  in  1  enable display scanner.
- scan_valid  out  1  one-cycle pulse; scan_addr and scan_data valid.
- scan_addr  out  6  scanned address.
- scan_data  out  4  scanned tile code.
- ready  out  1  board loaded; in SERVE state.
- busy  out  1  in DRAIN or LOAD state.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears every register:
  - all outputs return to 0;
  - state goes to IDLE;
  - scan pointer = 0, lk_pending = 0, rr flag = 0 (lookup preferred);
  - in-flight reads are discarded; no ack or valid is issued afterwards.
- States:
  - IDLE: start -> LOAD, with edge_word_in/center_word_in latched into EDGE_DATA_OUT/CENTER_DATA_OUT.
  - LOAD: WR=1 for exactly one cycle, then -> SERVE.
  - SERVE: start -> DRAIN, words latched at the start edge.
  - DRAIN: no new grants; waits until the read pipeline is empty (at most 2 cycles), then -> LOAD.
  - start in LOAD or DRAIN is ignored.
- WR is asserted only in LOAD. ADDR holds its last value outside grants.
- Grants happen only in SERVE and not in the cycle start is seen.
- Lookup eligibility: lk_req=1 and lk_pending=0. lk_pending is set on grant and cleared on ack.
- Scanner eligibility: scan_en=1.
- Arbitration (one grant per cycle):
  - only one side eligible: grant it;
  - both eligible: round-robin via rr flag, which toggles on every contested grant.
  - Under continuous contention the scanner gets at least one grant in every two cycles.
- Pipeline:
  - grant at edge t loads ADDR;
  - DATA_IN is sampled at edge t+1;
  - lk_ack or scan_valid is high in the cycle after edge t+1, i.e. 2 cycles after the grant edge.
- Lookup with lk_addr >= 36:
  - ADDR is not changed;
  - acked at the same latency with lk_data=0, lk_err=1.
- Scan pointer:
  - increments on each scanner grant, wrapping 35 -> 0;
  - holds while scan_en=0;
  - is not reset by scan_en toggling or by a reload;
  - scan_addr is the granted pointer value.
- lk_req while not in SERVE: stays pending and is not acked until SERVE.
- lk_req dropped before ack: protocol violation; the ack still fires.

Test Plan:
- Reset, start with edge_word_in=96'h0123...; center=48'hFEDCBA987654 -> WR=1 exactly 1 cycle, 1 cycle after start; ready=1 the cycle after WR.
- SERVE, scan_en=0, lk_req with lk_addr=25 -> ADDR=25 one cycle after grant; lk_ack 2 cycles after grant with lk_data=memory[25]=4'hE; exactly one ack while lk_req is held.
- scan_en=1 for 40 cycles alone -> scan_addr sequence 0..35,0..3, each with matching scan_data; scan_valid continuous.
- scan_en=1 plus back-to-back lookups to address 7 -> grants alternate; no scanner gap longer than 1 cycle; every lookup acked with the address-7 data.
- lk_addr=40 -> lk_ack with lk_err=1, lk_data=0; ADDR unchanged.
- start in SERVE with 2 reads in flight -> both complete before WR; reload data is seen by the next scan.
- rst_n=0 during LOAD -> WR=0 next cycle; IDLE; ready=0; no stray lk_ack.
